// File: rtl/decode_issue.sv
// RV32I decode/issue stage with a 32-entry busy scoreboard in front of the register file.
// Optional macro WB_BYPASS_EN lets a same-cycle writeback satisfy a pending operand.
`default_nettype none

module decode_issue #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_pc,
    input  logic [31:0]  in_insn,
    output logic         rf_ren,
    output logic [4:0]   rf_rs1,
    output logic [4:0]   rf_rs2,
    input  logic [W-1:0] rf_rs1_val,
    input  logic [W-1:0] rf_rs2_val,
    input  logic         wb_wen,
    input  logic [4:0]   wb_rd,
    input  logic [W-1:0] wb_rd_val,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_pc,
    output logic [3:0]   out_op,
    output logic [2:0]   out_funct3,
    output logic         out_funct7b5,
    output logic [4:0]   out_rd,
    output logic         out_rd_we,
    output logic [W-1:0] out_imm,
    output logic [W-1:0] out_rs1_val,
    output logic [W-1:0] out_rs2_val,
    output logic         out_illegal
);

    typedef enum logic [1:0] {EMPTY, CHECK, READ, OUT} state_t;

    localparam logic [3:0] OP_LUI    = 4'd0;
    localparam logic [3:0] OP_AUIPC  = 4'd1;
    localparam logic [3:0] OP_JAL    = 4'd2;
    localparam logic [3:0] OP_JALR   = 4'd3;
    localparam logic [3:0] OP_BRANCH = 4'd4;
    localparam logic [3:0] OP_LOAD   = 4'd5;
    localparam logic [3:0] OP_STORE  = 4'd6;
    localparam logic [3:0] OP_OPIMM  = 4'd7;
    localparam logic [3:0] OP_OP     = 4'd8;
    localparam logic [3:0] OP_MISC   = 4'd9;
    localparam logic [3:0] OP_ILL    = 4'd15;

    state_t state;
    state_t state_next;

    logic [W-1:0] pc_q;
    logic [31:0]  insn_q;
    logic [31:0]  busy;
    logic         byp1_q;
    logic         byp2_q;
    logic [W-1:0] byp_val_q;

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign rs1 = insn_q[19:15];
    assign rs2 = insn_q[24:20];
    assign rd  = insn_q[11:7];

    logic [3:0]  op;
    logic [31:0] imm32;
    logic        use1;
    logic        use2;
    logic        writes_rd;

    always_comb begin
        op        = OP_ILL;
        imm32     = '0;
        use1      = 1'b0;
        use2      = 1'b0;
        writes_rd = 1'b0;
        if (insn_q[1:0] == 2'b11) begin
            case (insn_q[6:2])
                5'b01101: begin
                    op        = OP_LUI;
                    imm32     = {insn_q[31:12], 12'b0};
                    writes_rd = 1'b1;
                end
                5'b00101: begin
                    op        = OP_AUIPC;
                    imm32     = {insn_q[31:12], 12'b0};
                    writes_rd = 1'b1;
                end
                5'b11011: begin
                    op        = OP_JAL;
                    imm32     = {{11{insn_q[31]}}, insn_q[31], insn_q[19:12],
                                 insn_q[20], insn_q[30:21], 1'b0};
                    writes_rd = 1'b1;
                end
                5'b11001: begin
                    op        = OP_JALR;
                    imm32     = {{20{insn_q[31]}}, insn_q[31:20]};
                    use1      = 1'b1;
                    writes_rd = 1'b1;
                end
                5'b11000: begin
                    op    = OP_BRANCH;
                    imm32 = {{19{insn_q[31]}}, insn_q[31], insn_q[7],
                             insn_q[30:25], insn_q[11:8], 1'b0};
                    use1  = 1'b1;
                    use2  = 1'b1;
                end
                5'b00000: begin
                    op        = OP_LOAD;
                    imm32     = {{20{insn_q[31]}}, insn_q[31:20]};
                    use1      = 1'b1;
                    writes_rd = 1'b1;
                end
                5'b01000: begin
                    op    = OP_STORE;
                    imm32 = {{20{insn_q[31]}}, insn_q[31:25], insn_q[11:7]};
                    use1  = 1'b1;
                    use2  = 1'b1;
                end
                5'b00100: begin
                    op        = OP_OPIMM;
                    imm32     = {{20{insn_q[31]}}, insn_q[31:20]};
                    use1      = 1'b1;
                    writes_rd = 1'b1;
                end
                5'b01100: begin
                    op        = OP_OP;
                    use1      = 1'b1;
                    use2      = 1'b1;
                    writes_rd = 1'b1;
                end
                5'b00011, 5'b11100: begin
                    op    = OP_MISC;
                    imm32 = {{20{insn_q[31]}}, insn_q[31:20]};
                    use1  = 1'b1;
                end
                default: op = OP_ILL;
            endcase
        end
    end

    // A writeback landing this cycle can satisfy a busy operand only with bypass compiled in.
    logic hit1;
    logic hit2;
`ifdef WB_BYPASS_EN
    assign hit1 = wb_wen & (wb_rd == rs1) & (rs1 != 5'd0);
    assign hit2 = wb_wen & (wb_rd == rs2) & (rs2 != 5'd0);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    logic hazard;
    assign hazard = (use1 & busy[rs1] & ~hit1) | (use2 & busy[rs2] & ~hit2);

    logic out_fire;
    logic accept;
    logic proceed;
    assign out_fire = (state == OUT) & out_ready;
    assign accept   = in_valid & in_ready;
    assign proceed  = (state == CHECK) & ~hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_valid) state_next = CHECK;
                CHECK: if (!hazard)  state_next = READ;
                READ:  state_next = OUT;
                OUT: begin
                    if (out_ready) state_next = in_valid ? CHECK : EMPTY;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == EMPTY) | out_fire;
        out_valid = (state == OUT);
        rf_ren    = proceed;
        rf_rs1    = proceed ? rs1 : 5'd0;
        rf_rs2    = proceed ? rs2 : 5'd0;
    end

    // An instruction accepted during a flush is latched but dropped, since the FSM returns to EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            insn_q    <= '0;
            byp1_q    <= 1'b0;
            byp2_q    <= 1'b0;
            byp_val_q <= '0;
        end else begin
            if (accept) begin
                pc_q   <= in_pc;
                insn_q <= in_insn;
            end
            if (proceed) begin
                byp1_q    <= hit1;
                byp2_q    <= hit2;
                byp_val_q <= wb_rd_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pc       <= '0;
            out_op       <= '0;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
            out_rd       <= '0;
            out_rd_we    <= 1'b0;
            out_imm      <= '0;
            out_rs1_val  <= '0;
            out_rs2_val  <= '0;
            out_illegal  <= 1'b0;
        end else if (state == READ) begin
            out_pc       <= pc_q;
            out_op       <= op;
            out_funct3   <= insn_q[14:12];
            out_funct7b5 <= insn_q[30];
            out_rd       <= rd;
            out_rd_we    <= writes_rd & (rd != 5'd0);
            out_imm      <= W'($signed(imm32));
            out_rs1_val  <= use1 ? (byp1_q ? byp_val_q : rf_rs1_val) : '0;
            out_rs2_val  <= use2 ? (byp2_q ? byp_val_q : rf_rs2_val) : '0;
            out_illegal  <= (op == OP_ILL);
        end
    end

    // Set applies after clear so an issue and a retire to the same register leave it busy.
    logic [31:0] set_vec;
    logic [31:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (out_fire && out_rd_we) set_vec = 32'd1 << out_rd;
        if (wb_wen && (wb_rd != 5'd0)) clr_vec = 32'd1 << wb_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= ((busy & ~clr_vec) | set_vec) & ~32'd1;
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: a scoreboard queue of expected decodes is filled on
// acceptance and drained when out_valid appears; a small register-file model answers reads.
`timescale 1ns/1ps

module tb_decode_issue;

    localparam int W = 32;
`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_pc = '0;
    logic [31:0]  in_insn = '0;
    logic         rf_ren;
    logic [4:0]   rf_rs1;
    logic [4:0]   rf_rs2;
    logic [W-1:0] rf_rs1_val;
    logic [W-1:0] rf_rs2_val;
    logic         wb_wen = 1'b0;
    logic [4:0]   wb_rd = '0;
    logic [W-1:0] wb_rd_val = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_pc;
    logic [3:0]   out_op;
    logic [2:0]   out_funct3;
    logic         out_funct7b5;
    logic [4:0]   out_rd;
    logic         out_rd_we;
    logic [W-1:0] out_imm;
    logic [W-1:0] out_rs1_val;
    logic [W-1:0] out_rs2_val;
    logic         out_illegal;

    decode_issue #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_insn(in_insn),
        .rf_ren(rf_ren), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_rd_val(wb_rd_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_imm(out_imm), .out_rs1_val(out_rs1_val),
        .out_rs2_val(out_rs2_val), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model: registered read, so a same-edge write returns the old value.
    logic [31:0] rf [32];
    logic [31:0] rd1_q = '0;
    logic [31:0] rd2_q = '0;
    assign rf_rs1_val = rd1_q;
    assign rf_rs2_val = rd2_q;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i * 17);
        end else begin
            if (rf_ren) begin
                rd1_q <= (rf_rs1 == 5'd0) ? 32'd0 : rf[rf_rs1];
                rd2_q <= (rf_rs2 == 5'd0) ? 32'd0 : rf[rf_rs2];
            end
            if (wb_wen && wb_rd != 5'd0) rf[wb_rd] <= wb_rd_val;
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] imm;
        logic [31:0] v1;
        logic [31:0] v2;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int accept_cyc = 0;

    localparam logic [31:0] ADDI_X5 = 32'h00700293;
    localparam logic [31:0] ADD_X6  = 32'h00528333;
    localparam logic [31:0] BEQ_M4  = 32'hfe000ee3;
    localparam logic [31:0] LUI_X0  = 32'h12345037;

    function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] op,
                                input logic [2:0] f3, input logic f7, input logic [4:0] rd,
                                input logic we, input logic [31:0] imm,
                                input logic [31:0] v1, input logic [31:0] v2, input logic ill);
        exp_t e;
        e.pc = pc; e.op = op; e.f3 = f3; e.f7 = f7; e.rd = rd;
        e.we = we; e.imm = imm; e.v1 = v1; e.v2 = v2; e.ill = ill;
        return e;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] insn, input exp_t e);
        int n;
        n = 0;
        in_pc = pc;
        in_insn = insn;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        checkValue("accept_ready", in_ready, 1);
        accept_cyc = cyc;
        sb.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input int lat);
        int n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        checkValue("out_valid", out_valid, 1);
        checkValue("latency", cyc - accept_cyc, lat);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            checkValue("out_pc", out_pc, e.pc);
            checkValue("out_op", out_op, e.op);
            checkValue("out_funct3", out_funct3, e.f3);
            checkValue("out_funct7b5", out_funct7b5, e.f7);
            checkValue("out_rd", out_rd, e.rd);
            checkValue("out_rd_we", out_rd_we, e.we);
            checkValue("out_imm", out_imm, e.imm);
            checkValue("out_rs1_val", out_rs1_val, e.v1);
            checkValue("out_rs2_val", out_rs2_val, e.v2);
            checkValue("out_illegal", out_illegal, e.ill);
        end
    endtask

    // Stall on busy x5, then retire x5 with val; called right after the dependent add is accepted.
    task automatic rawStall(input logic [31:0] val);
        checkValue("stall_a_ren", rf_ren, 0);
        step();
        checkValue("stall_b_ren", rf_ren, 0);
        wb_wen = 1'b1;
        wb_rd = 5'd5;
        wb_rd_val = val;
        #1;
        checkValue("wb_cycle_ren", rf_ren, BYP);
        step();
        wb_wen = 1'b0;
        #1;
        checkValue("after_wb_ren", rf_ren, BYP ? 0 : 1);
`ifndef WB_BYPASS_EN
        checkValue("after_wb_rs1", rf_rs1, 5);
        checkValue("after_wb_rs2", rf_rs2, 5);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) step();
        checkValue("rst_out_valid", out_valid, 0);
        checkValue("rst_in_ready", in_ready, 1);
        checkValue("rst_rf_ren", rf_ren, 0);
        checkValue("rst_rf_rs1", rf_rs1, 0);
        checkValue("rst_out_pc", out_pc, 0);
        rst_n = 1'b1;
        step();

        applyStimulus(32'h100, ADDI_X5, mk(32'h100, 4'd7, 3'd0, 1'b0, 5'd5, 1'b1, 32'd7, 0, 0, 1'b0));
        checkOutput(3);

        applyStimulus(32'h104, ADD_X6, mk(32'h104, 4'd8, 3'd0, 1'b0, 5'd6, 1'b1, 32'd0, 32'd7, 32'd7, 1'b0));
        rawStall(32'd7);
        out_ready = 1'b0;
        checkOutput(BYP ? 4 : 5);

        in_pc = 32'h108;
        in_insn = BEQ_M4;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checkValue("hold_out_valid", out_valid, 1);
            checkValue("hold_in_ready", in_ready, 0);
            checkValue("hold_out_pc", out_pc, 32'h104);
            checkValue("hold_out_rs1", out_rs1_val, 32'd7);
        end
        out_ready = 1'b1;
        applyStimulus(32'h108, BEQ_M4, mk(32'h108, 4'd4, 3'd0, 1'b1, 5'd29, 1'b0, 32'hfffffffc, 0, 0, 1'b0));
        checkOutput(3);

        applyStimulus(32'h10c, 32'h0, mk(32'h10c, 4'd15, 3'd0, 1'b0, 5'd0, 1'b0, 32'd0, 0, 0, 1'b1));
        checkOutput(3);

        applyStimulus(32'h110, LUI_X0, mk(32'h110, 4'd0, 3'd5, 1'b0, 5'd0, 1'b0, 32'h12345000, 0, 0, 1'b0));
        checkOutput(3);

        applyStimulus(32'h114, ADDI_X5, mk(32'h114, 4'd7, 3'd0, 1'b0, 5'd5, 1'b1, 32'd7, 0, 0, 1'b0));
        checkOutput(3);
        applyStimulus(32'h118, ADD_X6, mk(32'h118, 4'd8, 3'd0, 1'b0, 5'd6, 1'b1, 32'd0, 32'd9, 32'd9, 1'b0));
        checkValue("pre_flush_ren", rf_ren, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        void'(sb.pop_back());
        #1;
        checkValue("flush_out_valid", out_valid, 0);
        checkValue("flush_rf_ren", rf_ren, 0);
        checkValue("flush_in_ready", in_ready, 1);
        step();
        checkValue("flush_out_valid2", out_valid, 0);

        applyStimulus(32'h11c, ADD_X6, mk(32'h11c, 4'd8, 3'd0, 1'b0, 5'd6, 1'b1, 32'd0, 32'd9, 32'd9, 1'b0));
        rawStall(32'd9);
        checkOutput(BYP ? 4 : 5);

        applyStimulus(32'h120, LUI_X0, mk(32'h120, 4'd0, 3'd5, 1'b0, 5'd0, 1'b0, 32'h12345000, 0, 0, 1'b0));
        out_ready = 1'b0;
        checkOutput(3);
        step();
        checkValue("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        checkValue("midout_rst_valid", out_valid, 0);
        checkValue("midout_rst_pc", out_pc, 0);
        checkValue("midout_rst_imm", out_imm, 0);
        checkValue("midout_rst_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        checkValue("post_rst_valid", out_valid, 0);
        checkValue("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
